// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter
//
// Round-robin arbiter that shares one AXI-stream datapath between NUM_SRC
// requesters. A source is granted for a whole packet (up to tlast) or for at
// most MAX_BURST beats, whichever comes first. Granted beats pass through a
// single registered output stage that carries the source index as a sideband.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   s_in_tdata     in   NUM_SRC*DWIDTH, source i at [i*DWIDTH +: DWIDTH]
//   s_in_tvalid    in   NUM_SRC per-source valid
//   s_in_tlast     in   NUM_SRC per-source end-of-packet
//   s_in_tready    out  NUM_SRC per-source ready (only the granted bit can be set)
//   m_out_tdata    out  DWIDTH registered output data
//   m_out_tvalid   out  registered output valid
//   m_out_tlast    out  registered output last (copy of source tlast)
//   m_out_tid      out  IDX_W index of the source that produced the output beat
//   m_out_tready   in   downstream ready
//   grant_active   out  high while a source holds the lock
//   grant_idx      out  IDX_W currently or most recently granted source

module stream_rr_arbiter #(
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned IDX_W     = 2,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [NUM_SRC*DWIDTH-1:0] s_in_tdata,
    input  logic [NUM_SRC-1:0]        s_in_tvalid,
    input  logic [NUM_SRC-1:0]        s_in_tlast,
    output logic [NUM_SRC-1:0]        s_in_tready,

    output logic [DWIDTH-1:0]         m_out_tdata,
    output logic                      m_out_tvalid,
    output logic                      m_out_tlast,
    output logic [IDX_W-1:0]          m_out_tid,
    input  logic                      m_out_tready,

    output logic                      grant_active,
    output logic [IDX_W-1:0]          grant_idx
);

    typedef enum logic [0:0] {
        StIdle,
        StLock
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   grant_idx_q;
    logic [IDX_W-1:0]   last_grant_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               grant_active_q;

    logic [DWIDTH-1:0]  out_data_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic [IDX_W-1:0]   out_tid_q;

    // Signals of the currently granted source.
    logic               sel_valid;
    logic               sel_last;
    logic [DWIDTH-1:0]  sel_data;

    // Arbitration result for the IDLE decision.
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    logic               in_lock;
    logic               out_free;
    logic               accept;
    logic               rel_beat;

    //--------------------------------------------------------------------------
    // Granted-source multiplexer
    //--------------------------------------------------------------------------
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_idx_q == IDX_W'(i)) begin
                sel_valid = s_in_tvalid[i];
                sel_last  = s_in_tlast[i];
                sel_data  = s_in_tdata[i*DWIDTH +: DWIDTH];
            end
        end
    end

    //--------------------------------------------------------------------------
    // Round-robin pick: scan last_grant+1, last_grant+2, ... modulo NUM_SRC.
    // The offset loop runs from the farthest offset down so the nearest valid
    // source is the last (and therefore winning) assignment.
    //--------------------------------------------------------------------------
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = NUM_SRC; k >= 1; k--) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if ((i == (32'(last_grant_q) + k) % NUM_SRC) && s_in_tvalid[i]) begin
                    pick_valid = 1'b1;
                    pick_idx   = IDX_W'(i);
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Handshake
    //--------------------------------------------------------------------------
    assign in_lock  = (state_q == StLock);
    // Output register can take a beat if empty or draining this cycle.
    assign out_free = ~out_valid_q | m_out_tready;
    assign accept   = in_lock & sel_valid & out_free;
    // Counter holds the number of beats already accepted in this grant, so
    // the MAX_BURST-th beat is the one accepted while cnt_q == MAX_BURST-1.
    assign rel_beat = accept & (sel_last | (cnt_q == CNT_W'(MAX_BURST - 1)));

    always_comb begin
        s_in_tready = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            s_in_tready[i] = in_lock & (grant_idx_q == IDX_W'(i)) & out_free;
        end
    end

    //--------------------------------------------------------------------------
    // FSM, grant bookkeeping and output register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            grant_idx_q    <= '0;
            last_grant_q   <= IDX_W'(NUM_SRC - 1);
            cnt_q          <= '0;
            grant_active_q <= 1'b0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            out_tid_q      <= '0;
        end else begin
            // Output stage: load wins over drain so back-to-back beats stream.
            if (accept) begin
                out_data_q  <= sel_data;
                out_last_q  <= sel_last;
                out_tid_q   <= grant_idx_q;
                out_valid_q <= 1'b1;
            end else if (m_out_tready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        grant_idx_q    <= pick_idx;
                        cnt_q          <= '0;
                        grant_active_q <= 1'b1;
                        state_q        <= StLock;
                    end
                end
                StLock: begin
                    // A stalled source simply keeps the lock.
                    if (accept) begin
                        if (rel_beat) begin
                            state_q        <= StIdle;
                            grant_active_q <= 1'b0;
                            last_grant_q   <= grant_idx_q;
                            cnt_q          <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q        <= StIdle;
                    grant_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign m_out_tdata  = out_data_q;
    assign m_out_tvalid = out_valid_q;
    assign m_out_tlast  = out_last_q;
    assign m_out_tid    = out_tid_q;
    assign grant_active = grant_active_q;
    assign grant_idx    = grant_idx_q;

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Round-robin arbiter that shares one AXI-stream datapath (forward register slice chain into the systolic array feed) between NUM_SRC requesters.
- Grants one source per packet, bounded by tlast or a MAX_BURST beat limit.
- Forwards the granted source's beats through one registered output stage with a source-ID sideband.
- Sits between the per-port input buffers and the shared forward register slice.

Parameters:
- DWIDTH, 32, data width per beat.
- NUM_SRC, 4, number of requesting sources (2..8).
- IDX_W, 2, width of source index; must satisfy 2**IDX_W >= NUM_SRC.
- MAX_BURST, 16, maximum beats per grant before forced re-arbitration (>= 1).
- CNT_W, 5, beat counter width; must hold MAX_BURST.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_in_tdata  in  NUM_SRC*DWIDTH  source data; source i occupies bits [i*DWIDTH +: DWIDTH].
- s_in_tvalid  in  NUM_SRC  per-source valid.
- s_in_tlast  in  NUM_SRC  per-source end-of-packet.
- s_in_tready  out  NUM_SRC  per-source ready.
- m_out_tdata  out  DWIDTH  registered output data.
- m_out_tvalid  out  1  registered output valid.
- m_out_tlast  out  1  registered output last; copy of source tlast.
- m_out_tid  out  IDX_W  index of the source that produced the current output beat.
- m_out_tready  in  1  downstream ready.
- grant_active  out  1  high while in LOCK.
- grant_idx  out  IDX_W  currently or last granted source.

Behaviour:
- Reset (rst=1, asynchronous):
  - State returns to IDLE.
  - m_out_tdata, m_out_tvalid, m_out_tlast, m_out_tid and grant_idx clear to 0; grant_active clears to 0; beat counter clears to 0.
  - last_grant is set to NUM_SRC-1, so source 0 has top priority after reset.
  - s_in_tready is all 0.
  - A reset mid-packet drops the output beat and abandons the packet. There is no recovery; sources restart their packets.
- State machine, 2 states:
  - IDLE:
    - s_in_tready is all 0.
    - If any s_in_tvalid is high, select the first valid source scanning last_grant+1, last_grant+2, … modulo NUM_SRC.
    - On the next edge: grant_idx <= selected, state <= LOCK, counter <= 0.
    - No valid source: stay in IDLE.
    - Arbitration costs exactly 1 cycle.
  - LOCK:
    - s_in_tready[grant_idx] = ~m_out_tvalid | m_out_tready (combinational). All other ready bits are 0.
    - A beat is accepted when s_in_tvalid[g] & s_in_tready[g].
    - On acceptance, m_out_* load tdata, tlast and tid=g, and m_out_tvalid <= 1. The counter increments.
    - Release condition: accepted beat has tlast=1, or the counter reaches MAX_BURST-1 on the accepted beat. On release: state <= IDLE, last_grant <= g, counter <= 0.
    - A source dropping valid mid-packet keeps the lock; the arbiter waits indefinitely.
- Output stage:
  - m_out_tvalid clears when m_out_tready=1 and no beat is accepted that cycle.
  - Output data holds stable while m_out_tvalid=1 and m_out_tready=0.
  - Load and drain in the same cycle sustain one beat per clock.
- Latency: first beat of a new grant is accepted 1 cycle after the request is seen, and appears on m_out 1 cycle after acceptance.
- Re-arbitration bubble: one idle input cycle after each release. Back-to-back packets from different sources therefore reach at most 50% throughput for 1-beat packets.
- A forced MAX_BURST release does not set m_out_tlast. The source's remaining beats follow in a later grant with the same tid.
- Simultaneous request and release: a source releasing in cycle N is lowest priority at the IDLE decision in cycle N+1.
- Single source always requesting: re-granted immediately after the bubble.

Test Plan:
- Reset priority: reset, then assert tvalid on sources 0..3 simultaneously, each sending 1-beat packets (tlast=1), data 0xA0+i, m_out_tready=1. Required: output order tid 0,1,2,3, data 0xA0,0xA1,0xA2,0xA3, each beat separated by 1 bubble cycle.
- Packet lock: source 1 sends 4 beats 0x10..0x13 with tlast on the 4th; source 2 valid throughout. Required: all 4 source-1 beats are contiguous on m_out with tid=1; source 2 is first granted after the beat with tlast.
- Burst limit: MAX_BURST=16, source 0 sends 20 beats with tlast only on beat 20; source 3 requesting. Required: 16 beats with tid=0 and m_out_tlast=0, then source 3's packet, then the remaining 4 beats of source 0 with tlast on the last.
- Backpressure: granted source streaming, hold m_out_tready=0 for 5 cycles mid-packet. Required: s_in_tready[g]=0 after the output register fills; m_out_tdata stays stable; no beat is lost or duplicated after ready returns.
- Async reset mid-packet: assert rst between clock edges during LOCK. Required: m_out_tvalid=0, grant_active=0 and s_in_tready=0 immediately, without waiting for an edge. After release, source 0 has priority.
- Round-robin fairness: all 4 sources continuously send 2-beat packets for 40 grants. Required: each source receives exactly 10 grants in cyclic order.
